axil_gpio_banked: RTL and testbench

AXIL_GPIO_BANKED -- requirements
Module: axil_gpio_banked

---
 rtl/axil_gpio_banked.sv | 222 ++++++++++++++++++++++
 tb/tb_axil_gpio_banked.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_gpio_banked.sv
// AXI-lite banked GPIO: per-bank OUT/SET/CLR/IN/edge-enable/W1C status registers, level irq.
// Writes retire one cycle after AW and W are both held; reads return one cycle after AR; one outstanding op per channel.
module axil_gpio_banked #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int N_BANKS     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_WIDTH-1:0]               awaddr,
    input  logic [2:0]                          awprot,
    input  logic                                awvalid,
    output logic                                awready,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic [DATA_WIDTH/8-1:0]             wstrb,
    input  logic                                wvalid,
    output logic                                wready,
    output logic [1:0]                          bresp,
    output logic                                bvalid,
    input  logic                                bready,
    input  logic [ADDR_WIDTH-1:0]               araddr,
    input  logic [2:0]                          arprot,
    input  logic                                arvalid,
    output logic                                arready,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic [1:0]                          rresp,
    output logic                                rvalid,
    input  logic                                rready,
    output logic [N_BANKS-1:0][DATA_WIDTH-1:0]  gpio_out,
    input  logic [N_BANKS-1:0][DATA_WIDTH-1:0]  gpio_in,
    output logic                                irq
);

    localparam int BW = ADDR_WIDTH - 5;
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(SYNC_STAGES + 2);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_SET  = 3'd1;
    localparam logic [2:0] REG_CLR  = 3'd2;
    localparam logic [2:0] REG_IN   = 3'd3;
    localparam logic [2:0] REG_RISE = 3'd4;
    localparam logic [2:0] REG_FALL = 3'd5;
    localparam logic [2:0] REG_STAT = 3'd6;
    localparam logic [2:0] REG_RSVD = 3'd7;

    typedef logic [N_BANKS-1:0][DATA_WIDTH-1:0] bank_vec_t;

    bank_vec_t out_r, out_n;
    bank_vec_t rise_r, rise_n;
    bank_vec_t fall_r, fall_n;
    bank_vec_t stat_r, stat_n;
    bank_vec_t dly_r, sync_q;
    bank_vec_t rise_det, fall_det;

    logic [SYNC_STAGES-1:0][N_BANKS-1:0][DATA_WIDTH-1:0] sync_r;
    logic [CW-1:0] settle_cnt;
    logic          settled;

    // Write channel state
    logic                  aw_got, w_got;
    logic [ADDR_WIDTH-3:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic [DATA_WIDTH-1:0] wmask;
    logic [BW-1:0]         wbank;
    logic [2:0]            wreg;
    logic                  wr_fire, wr_err;

    // Read channel decode
    logic [BW-1:0]         rbank;
    logic [2:0]            rreg;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_val;

    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

    assign awready  = ~aw_got & ~bvalid;
    assign wready   = ~w_got & ~bvalid;
    assign arready  = ~rvalid;
    assign gpio_out = out_r;

    assign wbank   = waddr_q[ADDR_WIDTH-3:3];
    assign wreg    = waddr_q[2:0];
    assign wr_fire = aw_got & w_got;
    assign wr_err  = (wbank >= BW'(N_BANKS)) || (wreg == REG_IN) || (wreg == REG_RSVD);

    assign rbank  = araddr[ADDR_WIDTH-1:5];
    assign rreg   = araddr[4:2];
    assign rd_err = (rbank >= BW'(N_BANKS)) || (rreg == REG_SET) || (rreg == REG_CLR)
                    || (rreg == REG_RSVD);

    assign sync_q   = sync_r[SYNC_STAGES-1];
    assign rise_det = sync_q & ~dly_r;
    assign fall_det = ~sync_q & dly_r;
    // Edge flags stay masked until the synchronizer and delay flops hold real pin data.
    assign settled  = (settle_cnt == CW'(SYNC_STAGES + 1));

    always_comb begin
        wmask = '0;
        for (int i = 0; i < SW; i++) begin
            wmask[i*8 +: 8] = {8{wstrb_q[i]}};
        end
    end

    always_comb begin
        out_n  = out_r;
        rise_n = rise_r;
        fall_n = fall_r;
        stat_n = stat_r;
        for (int b = 0; b < N_BANKS; b++) begin
            if (wr_fire && !wr_err && (wbank == BW'(b))) begin
                case (wreg)
                    REG_OUT:  out_n[b]  = (out_r[b] & ~wmask) | (wdata_q & wmask);
                    REG_SET:  out_n[b]  = out_r[b] | (wdata_q & wmask);
                    REG_CLR:  out_n[b]  = out_r[b] & ~(wdata_q & wmask);
                    REG_RISE: rise_n[b] = (rise_r[b] & ~wmask) | (wdata_q & wmask);
                    REG_FALL: fall_n[b] = (fall_r[b] & ~wmask) | (wdata_q & wmask);
                    REG_STAT: stat_n[b] = stat_r[b] & ~(wdata_q & wmask);
                    default:  ;
                endcase
            end
            // OR-ing the edge set after the W1C clear makes a coincident edge win.
            if (settled) begin
                stat_n[b] = stat_n[b] | (rise_det[b] & rise_r[b]) | (fall_det[b] & fall_r[b]);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (rbank == BW'(b)) begin
                case (rreg)
                    REG_OUT:  rd_val = out_r[b];
                    REG_IN:   rd_val = sync_q[b];
                    REG_RISE: rd_val = rise_r[b];
                    REG_FALL: rd_val = fall_r[b];
                    REG_STAT: rd_val = stat_r[b];
                    default:  rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_r      <= '0;
            rise_r     <= '0;
            fall_r     <= '0;
            stat_r     <= '0;
            sync_r     <= '0;
            dly_r      <= '0;
            settle_cnt <= '0;
            irq        <= 1'b0;
        end else begin
            out_r  <= out_n;
            rise_r <= rise_n;
            fall_r <= fall_n;
            stat_r <= stat_n;
            sync_r[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
            dly_r <= sync_q;
            if (!settled) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            irq <= |stat_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (awvalid && awready) begin
                aw_got  <= 1'b1;
                waddr_q <= awaddr[ADDR_WIDTH-1:2];
            end
            if (wvalid && wready) begin
                w_got   <= 1'b1;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (wr_fire) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                bvalid <= 1'b1;
                bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_err ? '0 : rd_val;
            rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_gpio_banked.sv
// Scoreboard bench for axil_gpio_banked: expectations queued at stimulus time, popped when the DUT answers.
module tb_axil_gpio_banked;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int NB   = 2;
    localparam int SYNC = 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                    clk, rst;
    logic [AW-1:0]           awaddr, araddr;
    logic [2:0]              awprot, arprot;
    logic                    awvalid, awready, wvalid, wready, bvalid, bready;
    logic                    arvalid, arready, rvalid, rready;
    logic [DW-1:0]           wdata, rdata;
    logic [DW/8-1:0]         wstrb;
    logic [1:0]              bresp, rresp;
    logic [NB-1:0][DW-1:0]   gpio_out, gpio_in;
    logic                    irq;

    int n_tests;
    int n_fail;
    int b_hs;
    logic [31:0] exp_q[$];
    logic [1:0]  resp_q[$];

    axil_gpio_banked #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_BANKS(NB), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .gpio_out(gpio_out), .gpio_in(gpio_in), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bvalid && bready) b_hs <= b_hs + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got no_finish need finish");
        $fatal(1, "watchdog");
    end

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  wvalid  = 1'b0; end
            cyc++;
        end
        cyc = 0;
        while (!bvalid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        if (!bvalid) begin
            n_tests++; n_fail++;
            $display("FAIL write_timeout addr=%h got bvalid=0 need 1", a);
            awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx;
            return;
        end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int cyc;
        araddr = a; arvalid = 1'b1; cyc = 0;
        while (!arready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        if (!rvalid) begin
            n_tests++; n_fail++;
            $display("FAIL read_timeout addr=%h got rvalid=0 need 1", a);
            d = 'x; resp = 2'bxx;
            return;
        end
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++; $display("FAIL reset_ready got %b need 111", {awready, wready, arready});
        end
        n_tests++;
        if ({bvalid, rvalid, irq} !== 3'b000) begin
            n_fail++; $display("FAIL reset_valid_irq got %b need 000", {bvalid, rvalid, irq});
        end
        n_tests++;
        if (gpio_out !== '0) begin
            n_fail++; $display("FAIL reset_gpio_out got %h need 0", gpio_out);
        end
    endtask

    task automatic test_out_strobe();
        logic [1:0] r, er; logic [31:0] d, e;
        resp_q.push_back(OKAY);
        axi_write(16'h0000, 32'hA5A5_0000, 4'hC, r);
        er = resp_q.pop_front(); n_tests++;
        if (r !== er) begin n_fail++; $display("FAIL out_bresp got %h need %h", r, er); end
        exp_q.push_back(32'hA5A5_0000);
        e = exp_q.pop_front(); n_tests++;
        if (gpio_out[0] !== e) begin n_fail++; $display("FAIL out_gpio got %h need %h", gpio_out[0], e); end
        exp_q.push_back(32'hA5A5_0000);
        axi_read(16'h0000, d, r);
        e = exp_q.pop_front(); n_tests++;
        if (d !== e || r !== OKAY) begin
            n_fail++; $display("FAIL out_readback got %h/%h need %h/0", d, r, e);
        end
        exp_q.push_back(32'hA5A5_0078);
        axi_write(16'h0000, 32'h1234_5678, 4'h1, r);
        e = exp_q.pop_front(); n_tests++;
        if (gpio_out[0] !== e) begin n_fail++; $display("FAIL out_lane0 got %h need %h", gpio_out[0], e); end
    endtask

    task automatic test_set_clr();
        logic [1:0] r; logic [31:0] d, e;
        axi_write(16'h0020, 32'h0000_00F0, 4'hF, r);
        axi_write(16'h0024, 32'h0000_000F, 4'hF, r);
        axi_write(16'h0028, 32'h0000_0030, 4'hF, r);
        exp_q.push_back(32'h0000_00CF);
        e = exp_q.pop_front(); n_tests++;
        if (gpio_out[1] !== e) begin n_fail++; $display("FAIL setclr_gpio1 got %h need %h", gpio_out[1], e); end
        exp_q.push_back(32'h0000_00CF);
        axi_write(16'h0024, 32'h0000_FF00, 4'h1, r);
        e = exp_q.pop_front(); n_tests++;
        if (gpio_out[1] !== e) begin n_fail++; $display("FAIL set_masked got %h need %h", gpio_out[1], e); end
        exp_q.push_back(32'hA5A5_0078);
        e = exp_q.pop_front(); n_tests++;
        if (gpio_out[0] !== e) begin n_fail++; $display("FAIL setclr_bank0 got %h need %h", gpio_out[0], e); end
        resp_q.push_back(SLVERR);
        axi_read(16'h0024, d, r);
        n_tests++;
        if (r !== resp_q.pop_front() || d !== 32'h0) begin
            n_fail++; $display("FAIL read_set got %h/%h need 0/2", d, r);
        end
    endtask

    task automatic test_w_before_aw();
        int b0;
        b0 = b_hs;
        wdata = 32'h0000_1111; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1; wvalid = 1'b0;
        n_tests++;
        if (wready !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready got %b need 0", wready); end
        repeat (2) begin @(posedge clk); #1; end
        awaddr = 16'h0000; awvalid = 1'b1;
        @(posedge clk); #1; awvalid = 1'b0;
        n_tests++;
        if (bvalid !== 1'b0) begin n_fail++; $display("FAIL wfirst_early_b got %b need 0", bvalid); end
        @(posedge clk); #1;
        resp_q.push_back(OKAY);
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== resp_q.pop_front()) begin
            n_fail++; $display("FAIL wfirst_b got %b/%h need 1/0", bvalid, bresp);
        end
        exp_q.push_back(32'h0000_1111);
        n_tests++;
        if (gpio_out[0] !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL wfirst_gpio got %h need 00001111", gpio_out[0]);
        end
        bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_tests++;
        if (b_hs - b0 !== 1) begin n_fail++; $display("FAIL wfirst_bcount got %0d need 1", b_hs - b0); end
        n_tests++;
        if ({awready, wready} !== 2'b11) begin
            n_fail++; $display("FAIL wfirst_ready got %b need 11", {awready, wready});
        end
    endtask

    task automatic test_edge_irq();
        logic [1:0] r; logic [31:0] d;
        axi_write(16'h0010, 32'h1, 4'hF, r);
        gpio_in[0][0] = 1'b1;
        repeat (SYNC + 1) begin @(posedge clk); #1; end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b need 0", irq); end
        @(posedge clk); #1;
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got %b need 1", irq); end
        exp_q.push_back(32'h1);
        axi_read(16'h0018, d, r);
        n_tests++;
        if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL stat_rise got %h need 1", d); end
        exp_q.push_back(32'h1);
        axi_read(16'h000C, d, r);
        n_tests++;
        if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL in_read got %h need 1", d); end
        axi_write(16'h0018, 32'h1, 4'hF, r);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c got %b need 0", irq); end
        axi_write(16'h0014, 32'h2, 4'hF, r);
        gpio_in[0][1] = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_unenabled_rise got %b need 0", irq); end
        gpio_in[0][1] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        exp_q.push_back(32'h2);
        axi_read(16'h0018, d, r);
        n_tests++;
        if (d !== exp_q.pop_front() || irq !== 1'b1) begin
            n_fail++; $display("FAIL stat_fall got %h/irq%b need 2/irq1", d, irq);
        end
        axi_write(16'h0018, 32'h2, 4'hF, r);
        gpio_in[0][0] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_clear got %b need 0", irq); end
    endtask

    task automatic test_set_wins();
        logic [1:0] r; logic [31:0] d;
        axi_write(16'h0010, 32'h4, 4'hF, r);
        gpio_in[0][2] = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        gpio_in[0][2] = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        exp_q.push_back(32'h4);
        axi_read(16'h0018, d, r);
        n_tests++;
        if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL setwins_pre got %h need 4", d); end
        // Rising edge reaches STAT on the same edge as the W1C update below.
        gpio_in[0][2] = 1'b1;
        repeat (SYNC - 1) begin @(posedge clk); #1; end
        axi_write(16'h0018, 32'h4, 4'hF, r);
        exp_q.push_back(32'h4);
        axi_read(16'h0018, d, r);
        n_tests++;
        if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL setwins got %h need 4", d); end
        axi_write(16'h0018, 32'h4, 4'hF, r);
        exp_q.push_back(32'h0);
        axi_read(16'h0018, d, r);
        n_tests++;
        if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL setwins_clear got %h need 0", d); end
    endtask

    task automatic test_errors();
        logic [1:0] r; logic [31:0] d;
        logic [AW-1:0] rd_addrs[4];
        logic [AW-1:0] wr_addrs[3];
        rd_addrs = '{16'h0040, 16'h001C, 16'h0028, 16'h003C};
        wr_addrs = '{16'h000C, 16'h001C, 16'h0040};
        foreach (rd_addrs[i]) begin
            resp_q.push_back(SLVERR); exp_q.push_back(32'h0);
            axi_read(rd_addrs[i], d, r);
            n_tests++;
            if (r !== resp_q.pop_front() || d !== exp_q.pop_front()) begin
                n_fail++; $display("FAIL err_read %h got %h/%h need 0/2", rd_addrs[i], d, r);
            end
        end
        foreach (wr_addrs[i]) begin
            resp_q.push_back(SLVERR);
            axi_write(wr_addrs[i], 32'hFFFF_FFFF, 4'hF, r);
            n_tests++;
            if (r !== resp_q.pop_front()) begin
                n_fail++; $display("FAIL err_write %h got %h need 2", wr_addrs[i], r);
            end
        end
        n_tests++;
        if (gpio_out !== {32'h0000_00CF, 32'h0000_1111}) begin
            n_fail++; $display("FAIL err_nochange got %h need 000000cf00001111", gpio_out);
        end
        exp_q.push_back(32'h0000_1111);
        axi_read(16'h0003, d, r);
        n_tests++;
        if (d !== exp_q.pop_front() || r !== OKAY) begin
            n_fail++; $display("FAIL addr_low_bits got %h/%h need 00001111/0", d, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rw, rr; logic [31:0] d, v;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            exp_q.push_back(32'h0000_00CF);
            fork
                axi_write(16'h0034, v, 4'hF, rw);
                axi_read(16'h0020, d, rr);
            join
            n_tests++;
            if (d !== exp_q.pop_front() || rw !== OKAY || rr !== OKAY) begin
                n_fail++; $display("FAIL concurrent %0d got %h/%h/%h need cf/0/0", i, d, rw, rr);
            end
            exp_q.push_back(v);
            axi_read(16'h0034, d, rr);
            n_tests++;
            if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL fall_en_rb %0d got %h need %h", i, d, v); end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic [31:0] d;
        awaddr = 16'h0000; wdata = 32'h5555_AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bvalid !== 1'b1 || gpio_out[0] !== 32'h5555_AAAA) begin
            n_fail++; $display("FAIL rstmid_pre got %b/%h need 1/5555aaaa", bvalid, gpio_out[0]);
        end
        gpio_in = '0; gpio_in[1] = 32'h0000_00FF; rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        n_tests++;
        if (bvalid !== 1'b0 || gpio_out !== '0) begin
            n_fail++; $display("FAIL rstmid_clear got %b/%h need 0/0", bvalid, gpio_out);
        end
        n_tests++;
        if ({awready, wready, arready, irq} !== 4'b1110) begin
            n_fail++; $display("FAIL rstmid_ready got %b need 1110", {awready, wready, arready, irq});
        end
        axi_write(16'h0030, 32'hFF, 4'hF, r);
        repeat (8) begin @(posedge clk); #1; end
        exp_q.push_back(32'h0);
        axi_read(16'h0038, d, r);
        n_tests++;
        if (d !== exp_q.pop_front() || irq !== 1'b0) begin
            n_fail++; $display("FAIL no_spurious_edge got %h/irq%b need 0/irq0", d, irq);
        end
        resp_q.push_back(OKAY);
        axi_write(16'h0000, 32'hDEAD_BEEF, 4'hF, r);
        n_tests++;
        if (r !== resp_q.pop_front() || gpio_out[0] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rstmid_write got %h/%h need 0/deadbeef", r, gpio_out[0]);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        gpio_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_out_strobe();
        test_set_clr();
        test_w_before_aw();
        test_edge_irq();
        test_set_wins();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
